usb_txn_sequencer: RTL and testbench
====================================

Name: usb_txn_sequencer

Overview:
- Protocol-level controller between the host task interface (readData/writeData requests) and the USB packet engine (token/data/handshake encoder, NRZI, bit-stuffer, receiver).
- Sequences each request as two USB transactions:
  - Write: OUT to ADDR_ENDP carrying the flash address, then OUT to DATA_ENDP carrying the data.
  - Read: OUT to ADDR_ENDP carrying the address, then IN from DATA_ENDP.
- Owns retry counting and response timeouts, and returns one success/fail response per request.

Parameters:
- DEV_ADDR, 7'd5, USB device address placed in every token.
- ADDR_ENDP, 4'd4, endpoint receiving the flash address.
- DATA_ENDP, 4'd8, endpoint for flash data.
- MAX_TRIES, 8, attempts per transaction before abort.
- TIMEOUT, 255, clocks to wait for a device response after the last transmitted packet.

Ports:
- clk  in  1  system clock.
- rst_L  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  8  flash address.
- req_wdata  in  64  write data.
- req_ready  out  1  sequencer idle; request accepted when req_valid && req_ready.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_success  out  1  request completed (valid with rsp_valid).
- rsp_rdata  out  64  read data (valid with rsp_valid on a successful read).
- eng_cmd_valid  out  1  command to packet engine.
- eng_cmd_ready  in  1  engine accepts command.
- eng_cmd  out  2  SEND_TOKEN / SEND_DATA0 / SEND_HS.
- eng_pid  out  4  PID to send.
- eng_dev  out  7  token address field.
- eng_endp  out  4  token endpoint field.
- eng_payload  out  64  DATA0 payload; address zero-extended to 64 bits.
- eng_tx_done  in  1  pulse when the packet's EOP has completed.
- rx_valid  in  1  pulse when the receiver has decoded a packet.
- rx_pid  in  4  received PID.
- rx_ok  in  1  PID check and CRC good.
- rx_data  in  64  received payload.

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - rst_L=0 forces IDLE, retry count 0, timer 0.
  - Reset values: req_ready=1, rsp_valid=0, rsp_success=0, rsp_rdata=0, eng_cmd_valid=0, all eng_* fields 0.
  - A reset mid-operation abandons the request with no response.
- PIDs: OUT=0001, IN=1001, DATA0=0011, ACK=0010, NAK=1010.
- Engine handshake:
  - eng_cmd_valid and its fields are held stable until eng_cmd_ready.
  - The next command is not issued until eng_tx_done for the current one.
- Request acceptance:
  - In IDLE, a request with req_valid=1 is latched. The state moves to A_TOK next cycle, and req_ready=0 until the response.
  - The latched phase is ADDR for the first transaction and DATA for the second.
- OUT transaction (both ADDR and write DATA phases):
  - TOK: send OUT token with DEV_ADDR and the endpoint for the phase.
  - DAT: send DATA0; payload is the address (ADDR phase) or req_wdata (DATA phase).
  - HS_WAIT: on rx_valid with rx_ok and rx_pid=ACK, the transaction succeeds.
  - Failure: NAK, rx_ok=0, any other PID, or timeout. Increment tries; if tries<MAX_TRIES, return to TOK.
- IN transaction (read DATA phase):
  - TOK: send IN token with DEV_ADDR and DATA_ENDP.
  - D_WAIT: on rx_valid with rx_ok and DATA0, capture rx_data, send ACK handshake, and succeed after its eng_tx_done.
  - rx_ok=0: send NAK, then count a failure.
  - Timeout or wrong PID: count a failure, no handshake sent.
- Retries and abort:
  - tries resets to 0 at the start of each transaction.
  - tries reaching MAX_TRIES aborts with rsp_valid=1, rsp_success=0, rsp_rdata=0. An ADDR-phase abort skips the DATA phase.
- Timer:
  - Cleared on entry to a wait state and increments each cycle in it.
  - At count==TIMEOUT with no rx_valid, a timeout occurs. If rx_valid arrives in the same cycle, rx_valid wins.
- rx_valid outside the wait states is ignored.
- Completion:
  - DONE drives rsp_valid=1 for exactly one cycle, with rsp_success=1 and rsp_rdata = captured data on reads, 0 on writes.
  - Next cycle the state is IDLE and req_ready=1.
- States: IDLE, TOK, DAT, HS_WAIT, D_WAIT, SEND_HS, DONE. Phase and direction are held in registers.

Decomposition:
- usb_pkg holds:
  - pid_t enum.
  - eng_cmd_t enum.
  - seq_state_t enum.
  - phase_t enum {PH_ADDR, PH_DATA}.
- One sub-module, usb_resp_timer: clear, enable, expired output, parameter TIMEOUT.

Test Plan:
- Write addr=8'hAB, data=64'h0123_4567_89AB_CDEF, device ACKs every packet. Required engine command sequence:
  - OUT(5,4).
  - DATA0 with payload 64'hAB.
  - OUT(5,8).
  - DATA0 with payload 64'h0123_4567_89AB_CDEF.
  - Response: rsp_valid for one cycle, rsp_success=1.
- Read addr=8'h10, device returns DATA0 64'hDEAD_BEEF_CAFE_F00D with rx_ok=1 -> IN(5,8), then ACK sent; rsp_rdata=64'hDEAD_BEEF_CAFE_F00D, rsp_success=1.
- Write where the device NAKs the data OUT 3 times, then ACKs -> exactly 4 OUT(5,8)+DATA0 pairs, success=1.
- Read with rx_ok=0 on the first 2 DATA0 packets -> 2 NAKs sent, 3rd attempt ACKed, success=1.
- No device response at all -> 8 OUT(5,4) attempts, each preceded by 255 idle cycles after the previous attempt's eng_tx_done; rsp_success=0, no OUT(5,8) issued.
- rst_L=0 asserted during HS_WAIT -> next cycle req_ready=1, eng_cmd_valid=0, no rsp_valid.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared PID, engine command, FSM state and phase types for the USB transaction sequencer
package usb_pkg;

   typedef enum logic [3:0] {
      PID_OUT   = 4'b0001,
      PID_IN    = 4'b1001,
      PID_DATA0 = 4'b0011,
      PID_ACK   = 4'b0010,
      PID_NAK   = 4'b1010
   } pid_t;

   typedef enum logic [1:0] {
      CMD_SEND_TOKEN = 2'd0,
      CMD_SEND_DATA0 = 2'd1,
      CMD_SEND_HS    = 2'd2
   } eng_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TOK     = 3'd1,
      ST_DAT     = 3'd2,
      ST_HS_WAIT = 3'd3,
      ST_D_WAIT  = 3'd4,
      ST_SEND_HS = 3'd5,
      ST_DONE    = 3'd6
   } seq_state_t;

   typedef enum logic {
      PH_ADDR = 1'b0,
      PH_DATA = 1'b1
   } phase_t;

endpackage

// File: rtl/usb_resp_timer.sv
// rtl/usb_resp_timer.sv - device response timeout counter, saturates once expired
module usb_resp_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_L,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_L || clear) begin
         r_count <= '0;
      end else if (enable && !expired) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = (r_count == W'(TIMEOUT));

endmodule

// File: rtl/usb_txn_sequencer.sv
// rtl/usb_txn_sequencer.sv - turns host read/write requests into address-OUT plus data-OUT/IN USB transactions
module usb_txn_sequencer
   import usb_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR  = 7'd5,
   parameter logic [3:0] ADDR_ENDP = 4'd4,
   parameter logic [3:0] DATA_ENDP = 4'd8,
   parameter int         MAX_TRIES = 8,
   parameter int         TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst_L,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [7:0]  req_addr,
   input  logic [63:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic        rsp_success,
   output logic [63:0] rsp_rdata,
   output logic        eng_cmd_valid,
   input  logic        eng_cmd_ready,
   output logic [1:0]  eng_cmd,
   output logic [3:0]  eng_pid,
   output logic [6:0]  eng_dev,
   output logic [3:0]  eng_endp,
   output logic [63:0] eng_payload,
   input  logic        eng_tx_done,
   input  logic        rx_valid,
   input  logic [3:0]  rx_pid,
   input  logic        rx_ok,
   input  logic [63:0] rx_data
);

   localparam int TW = $clog2(MAX_TRIES + 1);

   seq_state_t  r_state,   w_state_n;
   phase_t      r_phase,   w_phase_n;
   pid_t        r_hs_pid,  w_hs_pid_n;
   logic        r_write,   w_write_n;
   logic [7:0]  r_addr,    w_addr_n;
   logic [63:0] r_wdata,   w_wdata_n;
   logic [63:0] r_rdata,   w_rdata_n;
   logic [TW-1:0] r_tries, w_tries_n;
   logic        r_sent,    w_sent_n;
   logic        r_success, w_success_n;

   logic w_timer_clr, w_timer_en, w_expired;
   logic w_txn_ok, w_txn_fail, w_is_in;

   usb_resp_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_L   (rst_L),
      .clear   (w_timer_clr),
      .enable  (w_timer_en),
      .expired (w_expired)
   );

   assign w_is_in = (r_phase == PH_DATA) && !r_write;

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         r_state   <= ST_IDLE;
         r_phase   <= PH_ADDR;
         r_hs_pid  <= PID_ACK;
         r_write   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_tries   <= '0;
         r_sent    <= 1'b0;
         r_success <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_phase   <= w_phase_n;
         r_hs_pid  <= w_hs_pid_n;
         r_write   <= w_write_n;
         r_addr    <= w_addr_n;
         r_wdata   <= w_wdata_n;
         r_rdata   <= w_rdata_n;
         r_tries   <= w_tries_n;
         r_sent    <= w_sent_n;
         r_success <= w_success_n;
      end
   end

   always_comb begin
      w_state_n     = r_state;
      w_phase_n     = r_phase;
      w_hs_pid_n    = r_hs_pid;
      w_write_n     = r_write;
      w_addr_n      = r_addr;
      w_wdata_n     = r_wdata;
      w_rdata_n     = r_rdata;
      w_tries_n     = r_tries;
      w_sent_n      = r_sent;
      w_success_n   = r_success;
      w_timer_clr   = 1'b1;
      w_timer_en    = 1'b0;
      w_txn_ok      = 1'b0;
      w_txn_fail    = 1'b0;
      eng_cmd_valid = 1'b0;
      eng_cmd       = CMD_SEND_TOKEN;
      eng_pid       = 4'd0;
      eng_dev       = 7'd0;
      eng_endp      = 4'd0;
      eng_payload   = 64'd0;

      // r_sent marks a command the engine has taken; wait for its EOP before moving on
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_n   = ST_TOK;
               w_phase_n   = PH_ADDR;
               w_write_n   = req_write;
               w_addr_n    = req_addr;
               w_wdata_n   = req_wdata;
               w_rdata_n   = '0;
               w_tries_n   = '0;
               w_sent_n    = 1'b0;
               w_success_n = 1'b0;
            end
         end
         ST_TOK: begin
            eng_cmd_valid = !r_sent;
            eng_cmd       = CMD_SEND_TOKEN;
            eng_pid       = w_is_in ? PID_IN : PID_OUT;
            eng_dev       = DEV_ADDR;
            eng_endp      = (r_phase == PH_ADDR) ? ADDR_ENDP : DATA_ENDP;
            if (!r_sent && eng_cmd_ready) w_sent_n = 1'b1;
            if (r_sent && eng_tx_done) begin
               w_sent_n  = 1'b0;
               w_state_n = w_is_in ? ST_D_WAIT : ST_DAT;
            end
         end
         ST_DAT: begin
            eng_cmd_valid = !r_sent;
            eng_cmd       = CMD_SEND_DATA0;
            eng_pid       = PID_DATA0;
            eng_payload   = (r_phase == PH_ADDR) ? {56'd0, r_addr} : r_wdata;
            if (!r_sent && eng_cmd_ready) w_sent_n = 1'b1;
            if (r_sent && eng_tx_done) begin
               w_sent_n  = 1'b0;
               w_state_n = ST_HS_WAIT;
            end
         end
         ST_HS_WAIT: begin
            w_timer_clr = 1'b0;
            w_timer_en  = 1'b1;
            if (rx_valid) begin
               if (rx_ok && rx_pid == PID_ACK) w_txn_ok = 1'b1;
               else w_txn_fail = 1'b1;
            end else if (w_expired) begin
               w_txn_fail = 1'b1;
            end
         end
         ST_D_WAIT: begin
            w_timer_clr = 1'b0;
            w_timer_en  = 1'b1;
            if (rx_valid) begin
               if (!rx_ok) begin
                  w_hs_pid_n = PID_NAK;
                  w_state_n  = ST_SEND_HS;
               end else if (rx_pid == PID_DATA0) begin
                  w_rdata_n  = rx_data;
                  w_hs_pid_n = PID_ACK;
                  w_state_n  = ST_SEND_HS;
               end else begin
                  w_txn_fail = 1'b1;
               end
            end else if (w_expired) begin
               w_txn_fail = 1'b1;
            end
         end
         ST_SEND_HS: begin
            eng_cmd_valid = !r_sent;
            eng_cmd       = CMD_SEND_HS;
            eng_pid       = r_hs_pid;
            if (!r_sent && eng_cmd_ready) w_sent_n = 1'b1;
            if (r_sent && eng_tx_done) begin
               w_sent_n = 1'b0;
               if (r_hs_pid == PID_ACK) w_txn_ok = 1'b1;
               else w_txn_fail = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_n = ST_IDLE;
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase

      if (w_txn_ok) begin
         if (r_phase == PH_ADDR) begin
            w_phase_n = PH_DATA;
            w_tries_n = '0;
            w_state_n = ST_TOK;
         end else begin
            w_success_n = 1'b1;
            w_state_n   = ST_DONE;
         end
      end

      // an abort in either phase goes straight to the failure response
      if (w_txn_fail) begin
         if (r_tries == TW'(MAX_TRIES - 1)) begin
            w_success_n = 1'b0;
            w_state_n   = ST_DONE;
         end else begin
            w_tries_n = r_tries + 1'b1;
            w_state_n = ST_TOK;
         end
      end
   end

   assign req_ready   = (r_state == ST_IDLE);
   assign rsp_valid   = (r_state == ST_DONE);
   assign rsp_success = rsp_valid && r_success;
   assign rsp_rdata   = (rsp_valid && r_success && !r_write) ? r_rdata : 64'd0;

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// tb/tb_usb_txn_sequencer.sv - scoreboard bench with engine/device model for usb_txn_sequencer
module tb_usb_txn_sequencer;

   logic        clk = 1'b0;
   logic        rst_L;
   logic        req_valid, req_write;
   logic [7:0]  req_addr;
   logic [63:0] req_wdata;
   logic        req_ready, rsp_valid, rsp_success;
   logic [63:0] rsp_rdata;
   logic        eng_cmd_valid, eng_cmd_ready;
   logic [1:0]  eng_cmd;
   logic [3:0]  eng_pid;
   logic [6:0]  eng_dev;
   logic [3:0]  eng_endp;
   logic [63:0] eng_payload;
   logic        eng_tx_done, rx_valid, rx_ok;
   logic [3:0]  rx_pid;
   logic [63:0] rx_data;

   usb_txn_sequencer dut (
      .clk(clk), .rst_L(rst_L),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_success(rsp_success), .rsp_rdata(rsp_rdata),
      .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready), .eng_cmd(eng_cmd),
      .eng_pid(eng_pid), .eng_dev(eng_dev), .eng_endp(eng_endp), .eng_payload(eng_payload),
      .eng_tx_done(eng_tx_done), .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_ok(rx_ok), .rx_data(rx_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [3:0]  pid;
      logic [6:0]  dev;
      logic [3:0]  endp;
      logic [63:0] pl;
   } cmd_s;

   typedef struct packed {
      logic        succ;
      logic [63:0] rd;
   } rsp_s;

   // device actions: 0 silent, 1 ACK, 2 NAK, 3 DATA0 good, 4 DATA0 with bad CRC
   cmd_s exp_cmd[$];
   rsp_s exp_rsp[$];
   int   dev_act[$];
   logic [63:0] dev_rdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_done_cyc = 0;
   int rsp_seen = 0;
   bit gap_mode = 0;
   int gap_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_tok(input logic [3:0] pid, input logic [3:0] endp);
      exp_cmd.push_back('{cmd: 2'd0, pid: pid, dev: 7'd5, endp: endp, pl: 64'd0});
   endtask

   task automatic push_dat(input logic [63:0] pl);
      exp_cmd.push_back('{cmd: 2'd1, pid: 4'b0011, dev: 7'd0, endp: 4'd0, pl: pl});
   endtask

   task automatic push_hs(input logic [3:0] pid);
      exp_cmd.push_back('{cmd: 2'd2, pid: pid, dev: 7'd0, endp: 4'd0, pl: 64'd0});
   endtask

   // engine + device model
   initial begin : engine
      logic [1:0] c;
      logic [3:0] p;
      int act;
      eng_cmd_ready = 0; eng_tx_done = 0;
      rx_valid = 0; rx_ok = 0; rx_pid = 0; rx_data = 0;
      forever begin
         @(negedge clk);
         if (eng_cmd_valid && rst_L) begin
            c = eng_cmd; p = eng_pid;
            eng_cmd_ready = 1;
            @(negedge clk); eng_cmd_ready = 0;
            @(negedge clk); @(negedge clk);
            eng_tx_done = 1; last_done_cyc = cyc;
            @(negedge clk); eng_tx_done = 0;
            if (c == 2'd1 || (c == 2'd0 && p == 4'b1001)) begin
               act = (dev_act.size() > 0) ? dev_act.pop_front() : 0;
               @(negedge clk); @(negedge clk);
               if (act != 0) begin
                  rx_valid = 1;
                  rx_ok    = (act != 4);
                  rx_pid   = (act == 1) ? 4'b0010 : (act == 2) ? 4'b1010 : 4'b0011;
                  rx_data  = (act == 3) ? dev_rdata : 64'h5555_AAAA_5555_AAAA;
                  @(negedge clk);
                  rx_valid = 0; rx_ok = 0;
               end
            end
         end
      end
   end

   initial begin : cmd_monitor
      bit prev = 0;
      cmd_s got, exp;
      forever begin
         @(negedge clk);
         if (eng_cmd_valid && !prev) begin
            got = '{cmd: eng_cmd, pid: eng_pid, dev: eng_dev, endp: eng_endp, pl: eng_payload};
            if (exp_cmd.size() == 0) begin
               check("cmd_unexpected", 96'(got), 96'(0));
            end else begin
               exp = exp_cmd.pop_front();
               check("cmd", 96'(got), 96'(exp));
            end
            if (gap_mode && got.cmd == 2'd0 && got.endp == 4'd4) begin
               if (gap_n > 0) check("timeout_gap", 96'(cyc - last_done_cyc), 96'(257));
               gap_n++;
            end
         end
         prev = eng_cmd_valid;
      end
   end

   initial begin : rsp_monitor
      rsp_s exp;
      forever begin
         @(negedge clk);
         if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
               check("rsp_unexpected", 96'(rsp_valid), 96'(0));
            end else begin
               exp = exp_rsp.pop_front();
               check("rsp_success", 96'(rsp_success), 96'(exp.succ));
               check("rsp_rdata", 96'(rsp_rdata), 96'(exp.rd));
            end
            rsp_seen++;
            @(negedge clk);
            check("rsp_one_cycle", 96'(rsp_valid), 96'(0));
            check("ready_after_rsp", 96'(req_ready), 96'(1));
         end
      end
   end

   task automatic issue(input logic wr, input logic [7:0] a, input logic [63:0] d);
      for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
      req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic run(input string name, input logic wr, input logic [7:0] a, input logic [63:0] d);
      int target;
      target = rsp_seen + 1;
      issue(wr, a, d);
      for (int i = 0; i < 6000 && rsp_seen < target; i++) @(negedge clk);
      if (rsp_seen < target) check({name, "_rsp_timeout"}, 96'(rsp_seen), 96'(target));
      repeat (3) @(negedge clk);
      check({name, "_cmds_consumed"}, 96'(exp_cmd.size()), 96'(0));
   endtask

   initial begin : main
      rst_L = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; dev_rdata = 0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 96'(req_ready), 96'(1));
      check("rst_rsp_valid", 96'(rsp_valid), 96'(0));
      check("rst_rsp_success", 96'(rsp_success), 96'(0));
      check("rst_rsp_rdata", 96'(rsp_rdata), 96'(0));
      check("rst_cmd_valid", 96'(eng_cmd_valid), 96'(0));
      check("rst_eng_fields", 96'({eng_cmd, eng_pid, eng_dev, eng_endp, eng_payload}), 96'(0));
      rst_L = 1;
      @(negedge clk);

      // plain write, all ACKed
      push_tok(4'b0001, 4'd4); push_dat(64'hAB);
      push_tok(4'b0001, 4'd8); push_dat(64'h0123_4567_89AB_CDEF);
      dev_act.push_back(1); dev_act.push_back(1);
      exp_rsp.push_back('{succ: 1'b1, rd: 64'd0});
      run("write", 1'b1, 8'hAB, 64'h0123_4567_89AB_CDEF);

      // plain read
      push_tok(4'b0001, 4'd4); push_dat(64'h10);
      push_tok(4'b1001, 4'd8); push_hs(4'b0010);
      dev_act.push_back(1); dev_act.push_back(3);
      dev_rdata = 64'hDEAD_BEEF_CAFE_F00D;
      exp_rsp.push_back('{succ: 1'b1, rd: 64'hDEAD_BEEF_CAFE_F00D});
      run("read", 1'b0, 8'h10, 64'd0);

      // data OUT NAKed three times
      push_tok(4'b0001, 4'd4); push_dat(64'h22);
      for (int i = 0; i < 4; i++) begin
         push_tok(4'b0001, 4'd8); push_dat(64'h1111_2222_3333_4444);
      end
      dev_act.push_back(1);
      dev_act.push_back(2); dev_act.push_back(2); dev_act.push_back(2); dev_act.push_back(1);
      exp_rsp.push_back('{succ: 1'b1, rd: 64'd0});
      run("write_nak", 1'b1, 8'h22, 64'h1111_2222_3333_4444);

      // read with two corrupted DATA0 packets
      push_tok(4'b0001, 4'd4); push_dat(64'h3C);
      push_tok(4'b1001, 4'd8); push_hs(4'b1010);
      push_tok(4'b1001, 4'd8); push_hs(4'b1010);
      push_tok(4'b1001, 4'd8); push_hs(4'b0010);
      dev_act.push_back(1);
      dev_act.push_back(4); dev_act.push_back(4); dev_act.push_back(3);
      dev_rdata = 64'h0F0E_0D0C_0B0A_0908;
      exp_rsp.push_back('{succ: 1'b1, rd: 64'h0F0E_0D0C_0B0A_0908});
      run("read_badcrc", 1'b0, 8'h3C, 64'd0);

      // silent device: eight address attempts then abort
      gap_mode = 1;
      for (int i = 0; i < 8; i++) begin
         push_tok(4'b0001, 4'd4); push_dat(64'h77);
         dev_act.push_back(0);
      end
      exp_rsp.push_back('{succ: 1'b0, rd: 64'd0});
      run("abort", 1'b1, 8'h77, 64'hFFFF_FFFF_FFFF_FFFF);
      check("abort_attempts", 96'(gap_n), 96'(8));
      gap_mode = 0;

      // reset while waiting for the handshake
      push_tok(4'b0001, 4'd4); push_dat(64'h5A);
      dev_act.push_back(0);
      issue(1'b1, 8'h5A, 64'h1234);
      for (int i = 0; i < 100 && exp_cmd.size() > 0; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      check("pre_reset_busy", 96'(req_ready), 96'(0));
      rst_L = 0;
      @(negedge clk);
      check("midrst_req_ready", 96'(req_ready), 96'(1));
      check("midrst_cmd_valid", 96'(eng_cmd_valid), 96'(0));
      check("midrst_rsp_valid", 96'(rsp_valid), 96'(0));
      rst_L = 1;
      begin
         int seen0;
         seen0 = rsp_seen;
         repeat (300) @(negedge clk);
         check("midrst_no_rsp", 96'(rsp_seen), 96'(seen0));
      end
      check("final_cmd_q", 96'(exp_cmd.size()), 96'(0));
      check("final_rsp_q", 96'(exp_rsp.size()), 96'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
